// File: rtl/speed_ctrl_pkg.sv
// Shared definitions for the speed-control loop: quadrature state codes,
// decoder step codes and the default speed width used by measurement and
// comparison blocks alike.
package speed_ctrl_pkg;

  // Default speed magnitude width shared with the speed comparator.
  localparam int DEF_SPD_W = 8;

  // Quadrature states as {a, b}; forward rotation walks Q00->Q10->Q11->Q01.
  typedef enum logic [1:0] {
    Q00 = 2'b00,
    Q10 = 2'b10,
    Q11 = 2'b11,
    Q01 = 2'b01
  } quad_t;

  // Per-cycle decoder result.
  typedef enum logic [1:0] {
    STEP_NONE = 2'd0,
    STEP_FWD  = 2'd1,
    STEP_REV  = 2'd2,
    STEP_ERR  = 2'd3
  } step_t;

  // Next state when rotating forward from s.
  function automatic logic [1:0] quad_fwd_next(input logic [1:0] s);
    case (s)
      Q00:     return Q10;
      Q10:     return Q11;
      Q11:     return Q01;
      default: return Q00;
    endcase
  endfunction

  // Classify a prev->cur transition; a change of both bits is illegal.
  function automatic step_t decode_step(input logic [1:0] prev, input logic [1:0] cur);
    if (cur == prev)                     return STEP_NONE;
    else if (cur == quad_fwd_next(prev)) return STEP_FWD;
    else if (prev == quad_fwd_next(cur)) return STEP_REV;
    else                                 return STEP_ERR;
  endfunction

endpackage

// File: rtl/speed_meas_if.sv
// Encoder inputs and speed result bundle for speed_meas.
//
// Handshake: speed_valid is a one-cycle strobe with no back-pressure.
// speed, dir and enc_err are meaningful when speed_valid=1 and hold
// their value until the next strobe; a consumer must take them on the
// strobe cycle or read the held value later.
interface speed_meas_if #(
  parameter int SPD_W = speed_ctrl_pkg::DEF_SPD_W
);
  logic             en;
  logic             enc_a;
  logic             enc_b;
  logic [SPD_W-1:0] speed;
  logic             dir;
  logic             speed_valid;
  logic             enc_err;

  modport master (
    output en, enc_a, enc_b,
    input  speed, dir, speed_valid, enc_err
  );

  modport slave (
    input  en, enc_a, enc_b,
    output speed, dir, speed_valid, enc_err
  );
endinterface

// File: rtl/speed_meas_quad_decoder.sv
// Quadrature decoder: synchronises the asynchronous encoder channels and
// emits one registered step code per clock. Keeps tracking regardless of
// measurement enable so the previous state is always current.
module quad_decoder
  import speed_ctrl_pkg::*;
(
  input  logic  clk,
  input  logic  reset,
  input  logic  enc_a,
  input  logic  enc_b,
  output step_t step
);

  logic [1:0] sync1;
  logic [1:0] sync2;
  logic [1:0] prev_ab;

  // Two-flop synchroniser, previous-state register and registered step code.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1   <= 2'b00;
      sync2   <= 2'b00;
      prev_ab <= 2'b00;
      step    <= STEP_NONE;
    end else begin
      sync1   <= {enc_a, enc_b};
      sync2   <= sync1;
      prev_ab <= sync2;
      step    <= decode_step(prev_ab, sync2);
    end
  end

endmodule

// File: rtl/speed_meas.sv
// Wheel speed measurement: counts net quadrature steps over a fixed
// window of clk cycles and publishes |net|, its sign and an error flag
// once per window.
module speed_meas
  import speed_ctrl_pkg::*;
#(
  parameter int WINDOW_CYCLES = 50000,
  parameter int WIN_W         = 16,
  parameter int SPD_W         = DEF_SPD_W
) (
  input  logic         clk,
  input  logic         reset,
  speed_meas_if.slave  bus
);

  localparam int                        ACC_W   = SPD_W + 1;
  localparam logic [WIN_W-1:0]          LAST    = WIN_W'(WINDOW_CYCLES - 1);
  localparam logic signed [ACC_W-1:0]   ACC_MAX = ACC_W'((1 << SPD_W) - 1);
  localparam logic signed [ACC_W-1:0]   ACC_MIN = -ACC_MAX;

  step_t                    step;
  logic [WIN_W-1:0]         win_cnt;
  logic signed [ACC_W-1:0]  acc;
  logic signed [ACC_W-1:0]  acc_next;
  logic [SPD_W-1:0]         speed_next;
  logic                     err_pend;
  logic                     step_err;
  logic                     terminal;
  logic [SPD_W-1:0]         speed_q;
  logic                     dir_q;
  logic                     valid_q;
  logic                     err_q;

  quad_decoder u_dec (
    .clk   (clk),
    .reset (reset),
    .enc_a (bus.enc_a),
    .enc_b (bus.enc_b),
    .step  (step)
  );

  // Saturating accumulate: a step that would pass the limit is dropped.
  always_comb begin
    acc_next = acc;
    case (step)
      STEP_FWD: if (acc != ACC_MAX) acc_next = acc + ACC_W'(1);
      STEP_REV: if (acc != ACC_MIN) acc_next = acc - ACC_W'(1);
      default:  acc_next = acc;
    endcase
  end

  assign step_err   = (step == STEP_ERR);
  assign terminal   = (win_cnt == LAST);
  assign speed_next = acc_next[SPD_W] ? SPD_W'(-acc_next) : acc_next[SPD_W-1:0];

  // Window counter, accumulator and output registers; the terminal cycle's
  // own step is folded into the closing window through acc_next.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      win_cnt  <= '0;
      acc      <= '0;
      err_pend <= 1'b0;
      speed_q  <= '0;
      dir_q    <= 1'b0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
    end else if (!bus.en) begin
      win_cnt  <= '0;
      acc      <= '0;
      err_pend <= 1'b0;
      valid_q  <= 1'b0;
    end else if (terminal) begin
      win_cnt  <= '0;
      acc      <= '0;
      err_pend <= 1'b0;
      speed_q  <= speed_next;
      dir_q    <= acc_next[SPD_W];
      err_q    <= err_pend | step_err;
      valid_q  <= 1'b1;
    end else begin
      win_cnt  <= win_cnt + WIN_W'(1);
      acc      <= acc_next;
      err_pend <= err_pend | step_err;
      valid_q  <= 1'b0;
    end
  end

  assign bus.speed       = speed_q;
  assign bus.dir         = dir_q;
  assign bus.speed_valid = valid_q;
  assign bus.enc_err     = err_q;

endmodule

// File: tb/tb_speed_meas.sv
// Directed bench for speed_meas: a 100-cycle-window instance for most
// scenarios and a 1000-cycle-window instance for saturation.
module tb_speed_meas;

  localparam int SPD_W = 8;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   failures = 0;
  logic [1:0] ab0;
  logic [1:0] ab1;

  speed_meas_if #(.SPD_W(SPD_W)) if0 ();
  speed_meas_if #(.SPD_W(SPD_W)) if1 ();

  assign {if0.enc_a, if0.enc_b} = ab0;
  assign {if1.enc_a, if1.enc_b} = ab1;

  speed_meas #(.WINDOW_CYCLES(100), .WIN_W(16), .SPD_W(SPD_W)) dut0 (
    .clk   (clk),
    .reset (reset),
    .bus   (if0.slave)
  );

  speed_meas #(.WINDOW_CYCLES(1000), .WIN_W(16), .SPD_W(SPD_W)) dut1 (
    .clk   (clk),
    .reset (reset),
    .bus   (if1.slave)
  );

  // Clock: 10 time-unit period.
  always #5 clk = ~clk;

  function automatic logic [1:0] fwd_of(input logic [1:0] s);
    case (s)
      2'b00:   return 2'b10;
      2'b10:   return 2'b11;
      2'b11:   return 2'b01;
      default: return 2'b00;
    endcase
  endfunction

  function automatic logic [1:0] rev_of(input logic [1:0] s);
    case (s)
      2'b00:   return 2'b01;
      2'b01:   return 2'b11;
      2'b11:   return 2'b10;
      default: return 2'b00;
    endcase
  endfunction

  // Advance n clocks, landing 1 time unit after the active edge.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One encoder step on the chosen instance, then hold for gap cycles.
  task automatic step(input int which, input bit rev, input int gap);
    if (which == 0) ab0 = rev ? rev_of(ab0) : fwd_of(ab0);
    else            ab1 = rev ? rev_of(ab1) : fwd_of(ab1);
    tick(gap);
  endtask

  // Edges until speed_valid is seen (0 when the budget runs out).
  task automatic wait_strobe(input int which, input int budget, output int edges);
    edges = 0;
    for (int i = 1; i <= budget; i++) begin
      tick(1);
      if (((which == 0) ? if0.speed_valid : if1.speed_valid) === 1'b1) begin
        edges = i;
        break;
      end
    end
  endtask

  task automatic test_reset;
    int e;
    reset = 1'b0;
    if0.en = 1'b0;
    if1.en = 1'b0;
    ab0 = 2'b00;
    ab1 = 2'b00;
    tick(2);
    checks++; if (if0.speed !== 8'd0) begin failures++; $display("FAIL rst_speed: got %0d expected 0", if0.speed); end
    checks++; if (if0.dir !== 1'b0) begin failures++; $display("FAIL rst_dir: got %b expected 0", if0.dir); end
    checks++; if (if0.speed_valid !== 1'b0) begin failures++; $display("FAIL rst_valid: got %b expected 0", if0.speed_valid); end
    checks++; if (if0.enc_err !== 1'b0) begin failures++; $display("FAIL rst_err: got %b expected 0", if0.enc_err); end
    reset = 1'b1;
    tick(2);
    if0.en = 1'b1;
    wait_strobe(0, 200, e);
    checks++; if (e !== 100) begin failures++; $display("FAIL idle_first_strobe: got %0d edges expected 100", e); end
    checks++; if (if0.speed !== 8'd0 || if0.dir !== 1'b0 || if0.enc_err !== 1'b0) begin
      failures++; $display("FAIL idle_outputs: got speed=%0d dir=%b err=%b expected 0/0/0", if0.speed, if0.dir, if0.enc_err); end
    tick(1);
    checks++; if (if0.speed_valid !== 1'b0) begin failures++; $display("FAIL strobe_width: got valid=%b expected 0", if0.speed_valid); end
    wait_strobe(0, 200, e);
    checks++; if (e !== 99) begin failures++; $display("FAIL idle_period: got %0d edges expected 99", e); end
    checks++; if (if0.speed !== 8'd0) begin failures++; $display("FAIL idle_speed2: got %0d expected 0", if0.speed); end
  endtask

  task automatic test_forward;
    int e;
    for (int i = 0; i < 20; i++) step(0, 1'b0, 2);
    wait_strobe(0, 200, e);
    checks++; if (e !== 60) begin failures++; $display("FAIL fwd_strobe: got %0d edges expected 60", e); end
    checks++; if (if0.speed !== 8'd20) begin failures++; $display("FAIL fwd_speed: got %0d expected 20", if0.speed); end
    checks++; if (if0.dir !== 1'b0) begin failures++; $display("FAIL fwd_dir: got %b expected 0", if0.dir); end
    wait_strobe(0, 200, e);
    checks++; if (e !== 100 || if0.speed !== 8'd0) begin
      failures++; $display("FAIL fwd_next_window: got edges=%0d speed=%0d expected 100/0", e, if0.speed); end
  endtask

  task automatic test_boundary;
    int e;
    // Encoder change on count 96 lands in the decoder on the terminal cycle.
    tick(96);
    step(0, 1'b0, 0);
    wait_strobe(0, 200, e);
    checks++; if (e !== 4 || if0.speed !== 8'd1) begin
      failures++; $display("FAIL term_step: got edges=%0d speed=%0d expected 4/1", e, if0.speed); end
    wait_strobe(0, 200, e);
    checks++; if (e !== 100 || if0.speed !== 8'd0) begin
      failures++; $display("FAIL term_after: got edges=%0d speed=%0d expected 100/0", e, if0.speed); end
    // One cycle later the step belongs to the following window.
    tick(97);
    step(0, 1'b0, 0);
    wait_strobe(0, 200, e);
    checks++; if (e !== 3 || if0.speed !== 8'd0) begin
      failures++; $display("FAIL late_step_close: got edges=%0d speed=%0d expected 3/0", e, if0.speed); end
    wait_strobe(0, 200, e);
    checks++; if (e !== 100 || if0.speed !== 8'd1) begin
      failures++; $display("FAIL late_step_next: got edges=%0d speed=%0d expected 100/1", e, if0.speed); end
    for (int i = 0; i < 5; i++) step(0, 1'b0, 2);
    for (int i = 0; i < 5; i++) step(0, 1'b1, 2);
    wait_strobe(0, 200, e);
    checks++; if (e !== 80 || if0.speed !== 8'd0 || if0.dir !== 1'b0) begin
      failures++; $display("FAIL mixed_net0: got edges=%0d speed=%0d dir=%b expected 80/0/0", e, if0.speed, if0.dir); end
    for (int i = 0; i < 3; i++) step(0, 1'b1, 2);
    wait_strobe(0, 200, e);
    checks++; if (e !== 94 || if0.speed !== 8'd3 || if0.dir !== 1'b1) begin
      failures++; $display("FAIL rev3: got edges=%0d speed=%0d dir=%b expected 94/3/1", e, if0.speed, if0.dir); end
  endtask

  task automatic test_illegal;
    int e;
    ab0 = ~ab0;
    tick(2);
    for (int i = 0; i < 3; i++) step(0, 1'b0, 2);
    wait_strobe(0, 200, e);
    checks++; if (e !== 92) begin failures++; $display("FAIL ill_strobe: got %0d edges expected 92", e); end
    checks++; if (if0.speed !== 8'd3 || if0.dir !== 1'b0) begin
      failures++; $display("FAIL ill_speed: got speed=%0d dir=%b expected 3/0", if0.speed, if0.dir); end
    checks++; if (if0.enc_err !== 1'b1) begin failures++; $display("FAIL ill_err: got %b expected 1", if0.enc_err); end
    wait_strobe(0, 200, e);
    checks++; if (e !== 100 || if0.enc_err !== 1'b0 || if0.speed !== 8'd0) begin
      failures++; $display("FAIL ill_clean: got edges=%0d err=%b speed=%0d expected 100/0/0", e, if0.enc_err, if0.speed); end
  endtask

  task automatic test_en_control;
    int e;
    int seen;
    for (int i = 0; i < 7; i++) step(0, 1'b0, 2);
    wait_strobe(0, 200, e);
    checks++; if (e !== 86 || if0.speed !== 8'd7) begin
      failures++; $display("FAIL en_pre: got edges=%0d speed=%0d expected 86/7", e, if0.speed); end
    for (int i = 0; i < 10; i++) step(0, 1'b0, 2);
    tick(30);
    if0.en = 1'b0;
    seen = 0;
    for (int i = 0; i < 120; i++) begin
      if (i < 8 && (i % 2) == 0) ab0 = fwd_of(ab0);
      tick(1);
      if (if0.speed_valid === 1'b1) seen++;
    end
    checks++; if (seen !== 0) begin failures++; $display("FAIL en_off_strobe: got %0d strobes expected 0", seen); end
    checks++; if (if0.speed !== 8'd7 || if0.dir !== 1'b0 || if0.enc_err !== 1'b0) begin
      failures++; $display("FAIL en_off_hold: got speed=%0d dir=%b err=%b expected 7/0/0", if0.speed, if0.dir, if0.enc_err); end
    if0.en = 1'b1;
    wait_strobe(0, 200, e);
    checks++; if (e !== 100) begin failures++; $display("FAIL en_rise_strobe: got %0d edges expected 100", e); end
    checks++; if (if0.speed !== 8'd0 || if0.enc_err !== 1'b0) begin
      failures++; $display("FAIL en_rise_speed: got speed=%0d err=%b expected 0/0", if0.speed, if0.enc_err); end
  endtask

  task automatic test_reset_mid;
    int e;
    ab0 = ~ab0;
    tick(2);
    for (int i = 0; i < 4; i++) step(0, 1'b1, 2);
    wait_strobe(0, 200, e);
    checks++; if (e !== 90 || if0.speed !== 8'd4 || if0.dir !== 1'b1 || if0.enc_err !== 1'b1) begin
      failures++; $display("FAIL rmid_pre: got edges=%0d speed=%0d dir=%b err=%b expected 90/4/1/1", e, if0.speed, if0.dir, if0.enc_err); end
    tick(30);
    #3;
    reset = 1'b0;
    ab0 = 2'b00;
    #1;
    checks++; if (if0.speed !== 8'd0 || if0.dir !== 1'b0 || if0.enc_err !== 1'b0 || if0.speed_valid !== 1'b0) begin
      failures++; $display("FAIL rmid_async: got speed=%0d dir=%b err=%b valid=%b expected all 0", if0.speed, if0.dir, if0.enc_err, if0.speed_valid); end
    tick(2);
    reset = 1'b1;
    wait_strobe(0, 200, e);
    checks++; if (e !== 100 || if0.speed !== 8'd0 || if0.enc_err !== 1'b0) begin
      failures++; $display("FAIL rmid_after: got edges=%0d speed=%0d err=%b expected 100/0/0", e, if0.speed, if0.enc_err); end
  endtask

  task automatic test_saturation;
    int e;
    if1.en = 1'b1;
    for (int i = 0; i < 300; i++) step(1, 1'b1, 3);
    wait_strobe(1, 1100, e);
    checks++; if (e !== 100) begin failures++; $display("FAIL sat_strobe: got %0d edges expected 100", e); end
    checks++; if (if1.speed !== 8'd255 || if1.dir !== 1'b1) begin
      failures++; $display("FAIL sat_rev: got speed=%0d dir=%b expected 255/1", if1.speed, if1.dir); end
    for (int i = 0; i < 300; i++) step(1, 1'b0, 3);
    for (int i = 0; i < 20; i++) step(1, 1'b1, 3);
    wait_strobe(1, 1100, e);
    checks++; if (e !== 40 || if1.speed !== 8'd235 || if1.dir !== 1'b0) begin
      failures++; $display("FAIL sat_fwd_drop: got edges=%0d speed=%0d dir=%b expected 40/235/0", e, if1.speed, if1.dir); end
    wait_strobe(1, 1100, e);
    checks++; if (e !== 1000 || if1.speed !== 8'd0) begin
      failures++; $display("FAIL sat_idle: got edges=%0d speed=%0d expected 1000/0", e, if1.speed); end
  endtask

  initial begin
    test_reset;
    test_forward;
    test_boundary;
    test_illegal;
    test_en_control;
    test_reset_mid;
    test_saturation;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/speed_meas.md
Name: speed_meas

Overview:
- Measures wheel speed from a quadrature encoder over a fixed sample window.
- Produces an 8-bit speed magnitude, a direction bit and a one-cycle valid strobe.
- Sits at the sensor end of the speed-control loop: speed and speed_valid drive the measured-speed input and enable of the speed comparator.

Parameters:
- WINDOW_CYCLES, 50000, clk cycles per sample window (1 ms at 50 MHz); legal range 2..65535.
- WIN_W, 16, width of the window counter; must hold WINDOW_CYCLES-1.
- SPD_W, 8, width of the speed output; the accumulator is SPD_W+1 bits signed.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset (asserted at 0).
- en  in  1  measurement enable.
- enc_a  in  1  encoder channel A, asynchronous to clk.
- enc_b  in  1  encoder channel B, asynchronous to clk.
- speed  out  SPD_W  |net steps| in the last completed window, saturated at 2^SPD_W-1.
- dir  out  1  sign of the last window: 1 = reverse (net negative), 0 = forward or zero.
- speed_valid  out  1  one-cycle pulse when speed/dir update.
- enc_err  out  1  set if any illegal transition occurred in the last completed window.

Behaviour:
- Reset (reset=0, async): all sync flops, prev-state, window counter and accumulator go to 0. speed=0, dir=0, speed_valid=0, enc_err=0.
- Input path: enc_a and enc_b each pass through a 2-flop synchronizer. The decoder compares the synced {a,b} with the registered previous {a,b}.
- Forward steps (+1): 00->10->11->01->00.
- Reverse steps (-1): the reverse of that sequence.
- No change: 0.
- Illegal step (both bits change): no count; sets the internal err_pend bit.
- Latency: encoder edge to accumulator update is 3 clk cycles.
- Accumulator: signed SPD_W+1 bits, saturating at +(2^SPD_W-1) and -(2^SPD_W-1). It never wraps. A step that would exceed the limit is dropped.
- Window counter: counts 0..WINDOW_CYCLES-1 while en=1. The terminal cycle is count==WINDOW_CYCLES-1.
- On the terminal cycle, the registered outputs update on the next edge, using the accumulator value that includes any step applied on the terminal cycle itself:
  - speed <= |acc|
  - dir <= (acc<0)
  - enc_err <= err_pend, or an illegal step on the terminal cycle
  - speed_valid <= 1 for exactly one cycle
  - acc <= 0, err_pend <= 0, counter <= 0
- No step is lost across the window boundary. Steps from terminal cycle N count in window N.
- en=0:
  - Window counter, acc and err_pend are held at 0.
  - speed_valid stays 0.
  - speed, dir and enc_err hold their last values.
  - Synchronizers and prev-state keep tracking, so there is no spurious step when en rises.
- en rising: the first full window starts on that cycle. The first speed_valid comes WINDOW_CYCLES cycles later.
- en falling mid-window: the partial window is discarded and no strobe is issued.
- Reset asserted mid-window: immediate clear as above. After release, the first window starts on the first cycle with en=1.
- speed_valid never asserts on two consecutive cycles (WINDOW_CYCLES>=2).

Decomposition:
- Shared package speed_ctrl_pkg holds:
  - the quadrature state encodings (Q00, Q10, Q11, Q01);
  - the step codes STEP_NONE, STEP_FWD, STEP_REV, STEP_ERR;
  - the default SPD_W, also used by the speed comparator.
- One sub-module, quad_decoder:
  - contains the synchronizers and prev-state register;
  - outputs a registered step code each cycle.
- speed_meas contains the window counter, saturating accumulator and output registers.

Test Plan (WINDOW_CYCLES=100 for simulation):
- Reset and idle: reset=0 then release, en=1, no encoder edges -> every 100 cycles speed_valid pulses for one cycle with speed=0, dir=0, enc_err=0.
- Forward count: 20 forward steps within one window -> speed=20, dir=0 at the strobe. The next window with no edges reports speed=0.
- Saturation: 300 reverse steps in one window (1 per 3 clk, WINDOW_CYCLES=1000) -> speed=255, dir=1, no wrap. A following idle window reports speed=0.
- Boundary: a forward step reaches the accumulator exactly on the terminal cycle -> counted in the closing window (speed=1), next window speed=0. Net +5/-5 mixed in one window -> speed=0, dir=0.
- Illegal transition: force {a,b} 00->11 once, plus 3 forward steps -> speed=3, enc_err=1 for that window. The next clean window gives enc_err=0.
- en and reset control:
  - en dropped at cycle 50 with 10 steps counted -> no strobe, outputs hold the previous values.
  - en raised again -> first strobe 100 cycles later.
  - reset pulsed mid-window -> all outputs 0 immediately (asynchronous).
